// File: rtl/fpga_computer_pkg.sv
// Shared slot map and ALU helper for the bus-based FPGA computer.
package fpga_computer_pkg;
  localparam logic [3:0] SLOT_PC  = 4'd0;
  localparam logic [3:0] SLOT_MAR = 4'd1;
  localparam logic [3:0] SLOT_RAM = 4'd2;
  localparam logic [3:0] SLOT_A   = 4'd3;
  localparam logic [3:0] SLOT_B   = 4'd4;
  localparam logic [3:0] SLOT_ALU = 4'd5;
  localparam logic [3:0] SLOT_OUT = 4'd6;
  localparam logic [3:0] SLOT_IR  = 4'd7;

  function automatic logic [7:0] alu_result(input logic [7:0] a, input logic [7:0] b,
                                            input logic sub);
    return sub ? (a - b) : (a + b);
  endfunction
endpackage

// File: rtl/fpga_computer_program_counter.sv
// 4-bit program counter: a load takes precedence over counting; wraps 15 -> 0.
module program_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic [3:0] count
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     count <= 4'd0;
    else if (load) count <= load_val;
    else if (en)   count <= count + 4'd1;
  end
endmodule

// File: rtl/fpga_computer.sv
// Bus-oriented teaching computer: 16 selectable slots around one bus register.
module fpga_computer
  import fpga_computer_pkg::*;
(
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] SEL,
  input  logic [7:0] PRGM_IN,
  input  logic       GO,
  input  logic       EN,
  input  logic       OE,
  input  logic       WE,
  input  logic       PRGM,
  input  logic       HLT,
  output logic [3:0] COUNT,
  output logic [7:0] BUS_OUT,
  output logic       ON
);
  logic [3:0] w_pc;
  logic [3:0] r_mar;
  logic [7:0] r_a, r_b, r_out, r_ir, r_bus;
  logic       r_halt;
  logic [7:0] r_ram [16];

  logic       w_wr;
  logic [7:0] w_wr_data;
  logic [7:0] w_rd;
  logic       w_pc_load, w_pc_en;

  assign w_wr      = GO && (PRGM || WE);
  assign w_wr_data = PRGM ? PRGM_IN : r_bus;
  assign w_pc_load = w_wr && (SEL == SLOT_PC);
  assign w_pc_en   = GO && EN && (SEL == SLOT_PC) && !r_halt;

  program_counter u_pc (
    .clk      (CLK),
    .reset    (RESET),
    .en       (w_pc_en),
    .load     (w_pc_load),
    .load_val (w_wr_data[3:0]),
    .count    (w_pc)
  );

  always_comb begin
    w_rd = 8'h00;
    case (SEL)
      SLOT_PC:  w_rd = {4'h0, w_pc};
      SLOT_MAR: w_rd = {4'h0, r_mar};
      SLOT_RAM: w_rd = r_ram[r_mar];
      SLOT_A:   w_rd = r_a;
      SLOT_B:   w_rd = r_b;
      SLOT_ALU: w_rd = alu_result(r_a, r_b, EN);
      SLOT_OUT: w_rd = r_out;
      SLOT_IR:  w_rd = r_ir;
      default:  w_rd = 8'h00;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_mar  <= 4'd0;
      r_a    <= 8'h00;
      r_b    <= 8'h00;
      r_out  <= 8'h00;
      r_ir   <= 8'h00;
      r_bus  <= 8'h00;
      r_halt <= 1'b0;
    end else begin
      // Halt latches even with GO low; only RESET clears it.
      if (HLT) r_halt <= 1'b1;
      if (GO) begin
        if (PRGM)    r_bus <= PRGM_IN;
        else if (OE) r_bus <= w_rd;
      end
      if (w_wr) begin
        case (SEL)
          SLOT_MAR: r_mar <= w_wr_data[3:0];
          SLOT_A:   r_a   <= w_wr_data;
          SLOT_B:   r_b   <= w_wr_data;
          SLOT_OUT: r_out <= w_wr_data;
          SLOT_IR:  r_ir  <= w_wr_data;
          default:  ;
        endcase
      end
    end
  end

  // RAM contents survive reset; writes are merely suppressed while it is held.
  always_ff @(posedge CLK) begin
    if (!RESET && w_wr && (SEL == SLOT_RAM)) r_ram[r_mar] <= w_wr_data;
  end

  assign COUNT   = w_pc;
  assign BUS_OUT = r_bus;
  assign ON      = !r_halt;
endmodule

// File: tb/tb_fpga_computer.sv
// Directed table-driven bench for fpga_computer plus hand sequences for halt/reset.
module tb_fpga_computer;
  logic       CLK = 1'b0;
  logic       RESET;
  logic [3:0] SEL;
  logic [7:0] PRGM_IN;
  logic       GO, EN, OE, WE, PRGM, HLT;
  logic [3:0] COUNT;
  logic [7:0] BUS_OUT;
  logic       ON;

  int errors = 0;
  int checks = 0;

  fpga_computer dut (
    .CLK(CLK), .RESET(RESET), .SEL(SEL), .PRGM_IN(PRGM_IN), .GO(GO), .EN(EN),
    .OE(OE), .WE(WE), .PRGM(PRGM), .HLT(HLT), .COUNT(COUNT), .BUS_OUT(BUS_OUT), .ON(ON)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string      name;
    int         n;
    logic [3:0] sel;
    logic [7:0] din;
    logic       go, en, oe, we, prgm;
    logic [3:0] exp_count;
    logic [7:0] exp_bus;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(string name, int n, logic [3:0] sel, logic [7:0] din,
                              logic go, logic en, logic oe, logic we, logic prgm,
                              logic [3:0] ec, logic [7:0] eb);
    vec_t v;
    v.name = name; v.n = n; v.sel = sel; v.din = din; v.go = go; v.en = en;
    v.oe = oe; v.we = we; v.prgm = prgm; v.exp_count = ec; v.exp_bus = eb;
    return v;
  endfunction

  task automatic chk(string name, logic [7:0] got, logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive(logic [3:0] sel, logic [7:0] din, logic go, logic en,
                       logic oe, logic we, logic prgm, logic hlt);
    SEL = sel; PRGM_IN = din; GO = go; EN = en; OE = oe; WE = we; PRGM = prgm; HLT = hlt;
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    #3;
    RESET = 1'b0;
    #1;
  endtask

  logic [3:0] frozen;

  initial begin
    drive(4'd0, 8'h00, 0, 0, 0, 0, 0, 0);
    RESET = 1'b0;
    @(negedge CLK);
    do_reset();
    chk("reset_count", {4'h0, COUNT}, 8'h00);
    chk("reset_bus", BUS_OUT, 8'h00);
    chk("reset_on", {7'h0, ON}, 8'h01);

    //          name           n  sel   din   go en oe we pr  cnt   bus
    vq.push_back(mk("cnt1",    1, 4'd0, 8'h00, 1, 1, 1, 0, 0, 4'd1, 8'h00));
    vq.push_back(mk("cnt4",    3, 4'd0, 8'h00, 1, 1, 1, 0, 0, 4'd4, 8'h03));
    vq.push_back(mk("cnt_wrap",12,4'd0, 8'h00, 1, 1, 1, 0, 0, 4'd0, 8'h0F));
    vq.push_back(mk("prgm_pc", 1, 4'd0, 8'hA5, 1, 1, 0, 0, 1, 4'd5, 8'hA5));
    vq.push_back(mk("go_low",  1, 4'd0, 8'h33, 0, 1, 1, 1, 1, 4'd5, 8'hA5));
    vq.push_back(mk("prgm_a",  1, 4'd3, 8'h12, 1, 0, 0, 0, 1, 4'd5, 8'h12));
    vq.push_back(mk("prgm_b",  1, 4'd4, 8'h30, 1, 0, 0, 0, 1, 4'd5, 8'h30));
    vq.push_back(mk("alu_add", 1, 4'd5, 8'h00, 1, 0, 1, 0, 0, 4'd5, 8'h42));
    vq.push_back(mk("alu_sub", 1, 4'd5, 8'h00, 1, 1, 1, 0, 0, 4'd5, 8'hE2));
    vq.push_back(mk("alu_add2",1, 4'd5, 8'h00, 1, 0, 1, 0, 0, 4'd5, 8'h42));
    vq.push_back(mk("out_we",  1, 4'd6, 8'h00, 1, 0, 0, 1, 0, 4'd5, 8'h42));
    vq.push_back(mk("slot9_oe",1, 4'd9, 8'h00, 1, 0, 1, 0, 0, 4'd5, 8'h00));
    vq.push_back(mk("out_rd",  1, 4'd6, 8'h00, 1, 0, 1, 0, 0, 4'd5, 8'h42));
    vq.push_back(mk("slot9_we",1, 4'd9, 8'h00, 1, 0, 0, 1, 0, 4'd5, 8'h42));
    vq.push_back(mk("slot9_rd",1, 4'd9, 8'h00, 1, 0, 1, 0, 0, 4'd5, 8'h00));
    vq.push_back(mk("prgm_mar",1, 4'd1, 8'hA7, 1, 0, 0, 0, 1, 4'd5, 8'hA7));
    vq.push_back(mk("mar_rd",  1, 4'd1, 8'h00, 1, 0, 1, 0, 0, 4'd5, 8'h07));
    vq.push_back(mk("prgm_ram",1, 4'd2, 8'h5C, 1, 0, 0, 0, 1, 4'd5, 8'h5C));
    vq.push_back(mk("a_rd",    1, 4'd3, 8'h00, 1, 0, 1, 0, 0, 4'd5, 8'h12));
    vq.push_back(mk("ram_rd",  1, 4'd2, 8'h00, 1, 0, 1, 0, 0, 4'd5, 8'h5C));
    vq.push_back(mk("prgm_ir", 1, 4'd7, 8'h99, 1, 0, 0, 0, 1, 4'd5, 8'h99));
    vq.push_back(mk("a_rd2",   1, 4'd3, 8'h00, 1, 0, 1, 0, 0, 4'd5, 8'h12));
    vq.push_back(mk("ir_rd",   1, 4'd7, 8'h00, 1, 0, 1, 0, 0, 4'd5, 8'h99));
    vq.push_back(mk("b_we",    1, 4'd4, 8'h00, 1, 0, 0, 1, 0, 4'd5, 8'h99));
    vq.push_back(mk("alu_b99", 1, 4'd5, 8'h00, 1, 0, 1, 0, 0, 4'd5, 8'hAB));
    vq.push_back(mk("ir_rd2",  1, 4'd7, 8'h00, 1, 0, 1, 0, 0, 4'd5, 8'h99));
    vq.push_back(mk("pc_we",   1, 4'd0, 8'h00, 1, 1, 0, 1, 0, 4'd9, 8'h99));

    foreach (vq[i]) begin
      drive(vq[i].sel, vq[i].din, vq[i].go, vq[i].en, vq[i].oe, vq[i].we, vq[i].prgm, 1'b0);
      for (int k = 0; k < vq[i].n; k++) tick();
      chk({vq[i].name, "_count"}, {4'h0, COUNT}, {4'h0, vq[i].exp_count});
      chk({vq[i].name, "_bus"}, BUS_OUT, vq[i].exp_bus);
    end
    drive(4'd0, 8'h00, 0, 0, 0, 0, 0, 0);

    // Halt while counting: counting stops after the halt clock.
    drive(4'd0, 8'h00, 1, 1, 1, 0, 0, 1);
    tick();
    chk("halt_on", {7'h0, ON}, 8'h00);
    frozen = COUNT;
    drive(4'd0, 8'h00, 1, 1, 1, 0, 0, 0);
    for (int k = 0; k < 3; k++) tick();
    chk("halt_frozen", {4'h0, COUNT}, {4'h0, frozen});
    chk("halt_on_hold", {7'h0, ON}, 8'h00);
    chk("halt_oe", BUS_OUT, {4'h0, frozen});
    drive(4'd0, 8'h03, 1, 1, 0, 0, 1, 0);
    tick();
    chk("halt_load", {4'h0, COUNT}, 8'h03);
    drive(4'd0, 8'h00, 0, 0, 0, 0, 0, 0);

    // Reset mid-cycle acts immediately, restoring ON.
    @(negedge CLK);
    do_reset();
    chk("rst2_on", {7'h0, ON}, 8'h01);
    chk("rst2_count", {4'h0, COUNT}, 8'h00);
    chk("rst2_bus", BUS_OUT, 8'h00);

    // Halt latches even with GO low.
    drive(4'd0, 8'h00, 0, 0, 0, 0, 0, 1);
    tick();
    chk("halt_go_low", {7'h0, ON}, 8'h00);
    drive(4'd0, 8'h00, 0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    do_reset();
    chk("rst3_on", {7'h0, ON}, 8'h01);

    // RAM contents survive reset: reselect address 7.
    drive(4'd1, 8'h07, 1, 0, 0, 0, 1, 0);
    tick();
    drive(4'd2, 8'h00, 1, 0, 1, 0, 0, 0);
    tick();
    chk("ram_keep", BUS_OUT, 8'h5C);
    drive(4'd0, 8'h00, 0, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
